// File: rtl/trig_ctrl_pkg.sv
// Shared types for the trigger-acceptance controller and its record FIFO.
package trig_ctrl_pkg;

    localparam int unsigned REC_COUNT_W = 32;
    localparam int unsigned PHASE_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DEAD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic [REC_COUNT_W-1:0] trig_num;
        logic [PHASE_W-1:0]     phase;
    } rec_t;

endpackage

// File: rtl/trig_rec_fifo.sv
// Small record FIFO with registered full/empty flags and a registered head word.
module trig_rec_fifo
    import trig_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type T = rec_t
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_push,
    input  T     i_push_data,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output T     o_head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_full;
    logic          r_empty;
    T              r_head;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_wr_next;
    logic [PW-1:0] w_rd_next;

    assign w_push    = i_push && !r_full;
    assign w_pop     = i_pop && !r_empty;
    assign w_wr_next = r_wr_ptr + PW'(w_push);
    assign w_rd_next = r_rd_ptr + PW'(w_pop);

    // Storage write; contents are meaningless until the pointers cover them.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    // Pointers and flags, flags computed from the next pointer values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_empty  <= (w_wr_next == w_rd_next);
            r_full   <= (w_wr_next[AW] != w_rd_next[AW]) &&
                        (w_wr_next[AW-1:0] == w_rd_next[AW-1:0]);
        end
    end

    // Head register: reload when the current head leaves or the FIFO is empty;
    // if the new head is the word being pushed this edge, bypass from the input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
        end else if (w_pop || r_empty) begin
            if (w_rd_next == r_wr_ptr) begin
                if (w_push) begin
                    r_head <= i_push_data;
                end
            end else begin
                r_head <= r_mem[w_rd_next[AW-1:0]];
            end
        end
    end

    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_head  = r_head;

endmodule

// File: rtl/trig_accept_ctrl.sv
// Run control and trigger acceptance: FSM, counters, veto logic and record logging.
module trig_accept_ctrl
    import trig_ctrl_pkg::*;
#(
    parameter int unsigned COUNT_W    = 32,
    parameter int unsigned DEAD_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk40,
    input  logic                 resetn,
    input  logic                 start_run,
    input  logic                 stop_run,
    input  logic [COUNT_W-1:0]   trig_limit,
    input  logic [DEAD_W-1:0]    deadtime,
    input  logic                 cand,
    input  logic [4:0]           cand_phase,
    input  logic                 busy_in,
    output logic                 accept,
    output logic                 running,
    output logic                 dead,
    output logic [COUNT_W-1:0]   trig_count,
    output logic [COUNT_W-1:0]   veto_count,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [COUNT_W+4:0]   rec_data,
    output logic [1:0]           state
);

    localparam int unsigned REC_W = COUNT_W + PHASE_W;

    state_t             r_state;
    state_t             w_state_next;
    logic [DEAD_W-1:0]  r_dead_cnt;
    logic [DEAD_W-1:0]  w_dead_cnt_next;
    logic [COUNT_W-1:0] r_trig_count;
    logic [COUNT_W-1:0] r_veto_count;
    logic [COUNT_W-1:0] w_trig_inc;
    logic               r_accept;
    logic               r_running;
    logic               r_dead;
    logic               w_accept;
    logic               w_veto;
    logic               w_clear;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [REC_W-1:0]   w_push_data;
    logic [REC_W-1:0]   w_head;

    assign w_trig_inc  = r_trig_count + COUNT_W'(1);
    assign w_push_data = {w_trig_inc, cand_phase};

    // Next-state, accept/veto decision and deadtime counter.
    always_comb begin
        w_state_next    = r_state;
        w_dead_cnt_next = r_dead_cnt;
        w_accept        = 1'b0;
        w_veto          = 1'b0;
        w_clear         = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start_run && !stop_run) begin
                    w_state_next = ST_ARMED;
                    w_clear      = 1'b1;
                end
            end
            ST_ARMED: begin
                if (stop_run) begin
                    w_state_next = ST_DRAIN;
                end else if (cand) begin
                    if (!busy_in && !w_fifo_full) begin
                        w_accept = 1'b1;
                        if ((trig_limit != '0) && (w_trig_inc == trig_limit)) begin
                            w_state_next = ST_DRAIN;
                        end else if (deadtime != '0) begin
                            w_state_next    = ST_DEAD;
                            w_dead_cnt_next = deadtime - DEAD_W'(1);
                        end
                    end else begin
                        w_veto = 1'b1;
                    end
                end
            end
            ST_DEAD: begin
                if (stop_run) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_veto = cand;
                    if (r_dead_cnt == '0) begin
                        w_state_next = ST_ARMED;
                    end else begin
                        w_dead_cnt_next = r_dead_cnt - DEAD_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (w_fifo_empty) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register with registered status decodes.
    always_ff @(posedge clk40 or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_dead_cnt <= '0;
            r_accept   <= 1'b0;
            r_running  <= 1'b0;
            r_dead     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_dead_cnt <= w_dead_cnt_next;
            r_accept   <= w_accept;
            r_running  <= (w_state_next == ST_ARMED) || (w_state_next == ST_DEAD);
            r_dead     <= (w_state_next == ST_DEAD);
        end
    end

    // Per-run trigger and (saturating) veto counters.
    always_ff @(posedge clk40 or negedge resetn) begin
        if (!resetn) begin
            r_trig_count <= '0;
            r_veto_count <= '0;
        end else if (w_clear) begin
            r_trig_count <= '0;
            r_veto_count <= '0;
        end else begin
            if (w_accept) begin
                r_trig_count <= w_trig_inc;
            end
            if (w_veto && (r_veto_count != '1)) begin
                r_veto_count <= r_veto_count + COUNT_W'(1);
            end
        end
    end

    trig_rec_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (logic [REC_W-1:0])
    ) u_fifo (
        .i_clk       (clk40),
        .i_rst_n     (resetn),
        .i_push      (w_accept),
        .i_push_data (w_push_data),
        .i_pop       (rec_ready),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head      (w_head)
    );

    assign accept     = r_accept;
    assign running    = r_running;
    assign dead       = r_dead;
    assign trig_count = r_trig_count;
    assign veto_count = r_veto_count;
    assign rec_valid  = !w_fifo_empty;
    assign rec_data   = w_head;
    assign state      = r_state;

endmodule

// File: tb/tb_trig_accept_ctrl.sv
// Bench for trig_accept_ctrl: vector table for per-cycle behaviour, scoreboard for records.
module tb_trig_accept_ctrl;

    localparam int unsigned COUNT_W = 32;
    localparam int unsigned DEAD_W  = 16;

    logic               clk40 = 1'b0;
    logic               resetn;
    logic               start_run, stop_run, cand, busy_in, rec_ready;
    logic [COUNT_W-1:0] trig_limit;
    logic [DEAD_W-1:0]  deadtime;
    logic [4:0]         cand_phase;
    logic               accept, running, dead, rec_valid;
    logic [COUNT_W-1:0] trig_count, veto_count;
    logic [COUNT_W+4:0] rec_data;
    logic [1:0]         state;

    int total = 0;
    int bad   = 0;

    logic [COUNT_W+4:0] sb [$];

    typedef struct {
        logic        start, stop, cand;
        logic [4:0]  ph;
        logic        busy, ready;
        logic [15:0] dt;
        logic [31:0] lim;
        logic        acc;
        logic [1:0]  st;
        logic [31:0] trig, veto;
        logic        chkv, v;
    } vec_t;

    vec_t tbl [$];

    trig_accept_ctrl #(.COUNT_W(COUNT_W), .DEAD_W(DEAD_W), .FIFO_DEPTH(4)) dut (
        .clk40      (clk40),
        .resetn     (resetn),
        .start_run  (start_run),
        .stop_run   (stop_run),
        .trig_limit (trig_limit),
        .deadtime   (deadtime),
        .cand       (cand),
        .cand_phase (cand_phase),
        .busy_in    (busy_in),
        .accept     (accept),
        .running    (running),
        .dead       (dead),
        .trig_count (trig_count),
        .veto_count (veto_count),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_data   (rec_data),
        .state      (state)
    );

    always #5 clk40 = ~clk40;

    function automatic vec_t mk(int s, int p, int c, int ph, int b, int r, int dt, int lim,
                                int acc, int st, int trig, int veto, int chkv, int v);
        vec_t x;
        x.start = 1'(s);   x.stop = 1'(p);   x.cand = 1'(c);   x.ph = 5'(ph);
        x.busy  = 1'(b);   x.ready = 1'(r);  x.dt = 16'(dt);   x.lim = 32'(lim);
        x.acc   = 1'(acc); x.st = 2'(st);    x.trig = 32'(trig); x.veto = 32'(veto);
        x.chkv  = 1'(chkv); x.v = 1'(v);
        return x;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Records leave the DUT on the edge after this negedge; compare against the oldest expected.
    always @(negedge clk40) begin
        if (resetn && rec_valid && rec_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected act=%0h exp=none", rec_data);
            end else begin
                logic [COUNT_W+4:0] e;
                e = sb.pop_front();
                if (rec_data !== e) begin
                    bad++;
                    $display("FAIL pop_data act=%0h exp=%0h", rec_data, e);
                end
            end
        end
    end

    initial begin
        // state codes: 0 IDLE, 1 ARMED, 2 DEAD, 3 DRAIN
        // deadtime 2: accepts at first cand and after two dead cycles; busy veto; start+stop
        tbl.push_back(mk(1,0,0, 0,0,1, 2,0, 0,1,0,0, 0,0));
        tbl.push_back(mk(0,0,0, 0,0,1, 2,0, 0,1,0,0, 0,0));
        tbl.push_back(mk(0,0,1, 5,0,1, 2,0, 1,2,1,0, 0,0));
        tbl.push_back(mk(0,0,1, 6,0,1, 2,0, 0,2,1,1, 0,0));
        tbl.push_back(mk(0,0,1, 7,0,1, 2,0, 0,1,1,2, 0,0));
        tbl.push_back(mk(0,0,1, 8,0,1, 2,0, 1,2,2,2, 0,0));
        tbl.push_back(mk(0,0,0, 0,0,1, 2,0, 0,2,2,2, 0,0));
        tbl.push_back(mk(0,0,0, 0,0,1, 2,0, 0,1,2,2, 1,0));
        tbl.push_back(mk(0,0,1, 3,1,1, 2,0, 0,1,2,3, 0,0));
        tbl.push_back(mk(0,1,0, 0,0,1, 2,0, 0,3,2,3, 0,0));
        tbl.push_back(mk(0,0,0, 0,0,1, 2,0, 0,0,2,3, 0,0));
        tbl.push_back(mk(1,1,0, 0,0,1, 2,0, 0,0,2,3, 0,0));
        // trig_limit 3 with continuous candidates
        tbl.push_back(mk(1,0,0, 0,0,1, 0,3, 0,1,0,0, 0,0));
        tbl.push_back(mk(0,0,1, 0,0,1, 0,3, 1,1,1,0, 0,0));
        tbl.push_back(mk(0,0,1, 1,0,1, 0,3, 1,1,2,0, 0,0));
        tbl.push_back(mk(0,0,1, 2,0,1, 0,3, 1,3,3,0, 0,0));
        tbl.push_back(mk(0,0,1, 3,0,1, 0,3, 0,3,3,0, 0,0));
        tbl.push_back(mk(0,0,1, 4,0,1, 0,3, 0,0,3,0, 0,0));
        tbl.push_back(mk(0,0,1, 5,0,1, 0,3, 0,0,3,0, 0,0));
        // FIFO full vetoes, then drain in order
        tbl.push_back(mk(1,0,0, 0,0,0, 0,0, 0,1,0,0, 0,0));
        tbl.push_back(mk(0,0,1,10,0,0, 0,0, 1,1,1,0, 0,0));
        tbl.push_back(mk(0,0,1,11,0,0, 0,0, 1,1,2,0, 0,0));
        tbl.push_back(mk(0,0,1,12,0,0, 0,0, 1,1,3,0, 0,0));
        tbl.push_back(mk(0,0,1,13,0,0, 0,0, 1,1,4,0, 0,0));
        tbl.push_back(mk(0,0,1,14,0,0, 0,0, 0,1,4,1, 0,0));
        tbl.push_back(mk(0,0,1,15,0,0, 0,0, 0,1,4,2, 1,1));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,1,4,2, 1,1));
        tbl.push_back(mk(0,0,0, 0,0,1, 0,0, 0,1,4,2, 0,0));
        tbl.push_back(mk(0,0,0, 0,0,1, 0,0, 0,1,4,2, 0,0));
        tbl.push_back(mk(0,0,0, 0,0,1, 0,0, 0,1,4,2, 0,0));
        tbl.push_back(mk(0,0,0, 0,0,1, 0,0, 0,1,4,2, 1,0));
        tbl.push_back(mk(0,1,0, 0,0,1, 0,0, 0,3,4,2, 0,0));
        tbl.push_back(mk(0,0,0, 0,0,1, 0,0, 0,0,4,2, 0,0));
        // stop during DEAD with two records queued
        tbl.push_back(mk(1,0,0, 0,0,0, 1,0, 0,1,0,0, 0,0));
        tbl.push_back(mk(0,0,1,20,0,0, 1,0, 1,2,1,0, 0,0));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,0, 0,1,1,0, 0,0));
        tbl.push_back(mk(0,0,1,21,0,0, 1,0, 1,2,2,0, 0,0));
        tbl.push_back(mk(0,1,1,22,0,0, 1,0, 0,3,2,0, 0,0));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,0, 0,3,2,0, 1,1));
        tbl.push_back(mk(0,0,0, 0,0,1, 1,0, 0,3,2,0, 0,0));
        tbl.push_back(mk(0,0,0, 0,0,1, 1,0, 0,3,2,0, 0,0));
        tbl.push_back(mk(0,0,0, 0,0,1, 1,0, 0,0,2,0, 1,0));
        // three records queued, ending in DEAD before a reset
        tbl.push_back(mk(1,0,0, 0,0,0, 1,0, 0,1,0,0, 0,0));
        tbl.push_back(mk(0,0,1, 1,0,0, 1,0, 1,2,1,0, 0,0));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,0, 0,1,1,0, 0,0));
        tbl.push_back(mk(0,0,1, 2,0,0, 1,0, 1,2,2,0, 0,0));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,0, 0,1,2,0, 0,0));
        tbl.push_back(mk(0,0,1, 3,0,0, 1,0, 1,2,3,0, 1,1));

        resetn = 1'b0; start_run = 1'b0; stop_run = 1'b0; cand = 1'b0; busy_in = 1'b0;
        rec_ready = 1'b0; trig_limit = '0; deadtime = '0; cand_phase = '0;
        repeat (3) @(posedge clk40);
        #1;
        chk("rst_state", 64'(state), 64'(0));
        chk("rst_accept", 64'(accept), 64'(0));
        chk("rst_running", 64'(running), 64'(0));
        chk("rst_dead", 64'(dead), 64'(0));
        chk("rst_valid", 64'(rec_valid), 64'(0));
        chk("rst_trig", 64'(trig_count), 64'(0));
        chk("rst_veto", 64'(veto_count), 64'(0));
        chk("rst_data", 64'(rec_data), 64'(0));
        resetn = 1'b1;

        foreach (tbl[i]) begin
            vec_t v;
            v = tbl[i];
            start_run = v.start; stop_run = v.stop; cand = v.cand; cand_phase = v.ph;
            busy_in = v.busy; rec_ready = v.ready; deadtime = v.dt; trig_limit = v.lim;
            if (v.acc) sb.push_back({v.trig, v.ph});
            @(posedge clk40);
            #1;
            chk($sformatf("r%0d_accept", i), 64'(accept), 64'(v.acc));
            chk($sformatf("r%0d_state", i), 64'(state), 64'(v.st));
            chk($sformatf("r%0d_running", i), 64'(running), 64'((v.st == 2'd1) || (v.st == 2'd2)));
            chk($sformatf("r%0d_dead", i), 64'(dead), 64'(v.st == 2'd2));
            chk($sformatf("r%0d_trig", i), 64'(trig_count), 64'(v.trig));
            chk($sformatf("r%0d_veto", i), 64'(veto_count), 64'(v.veto));
            if (v.chkv) begin
                chk($sformatf("r%0d_valid", i), 64'(rec_valid), 64'(v.v));
                if (v.v) begin
                    chk($sformatf("r%0d_sb_nonempty", i), 64'(sb.size() != 0), 64'(1));
                    if (sb.size() != 0) chk($sformatf("r%0d_head", i), 64'(rec_data), 64'(sb[0]));
                end
            end
        end

        // Asynchronous reset while DEAD with three records queued.
        start_run = 1'b0; stop_run = 1'b0; cand = 1'b0; rec_ready = 1'b0;
        resetn = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_state", 64'(state), 64'(0));
        chk("mid_rst_valid", 64'(rec_valid), 64'(0));
        chk("mid_rst_trig", 64'(trig_count), 64'(0));
        chk("mid_rst_veto", 64'(veto_count), 64'(0));
        chk("mid_rst_dead", 64'(dead), 64'(0));
        chk("mid_rst_accept", 64'(accept), 64'(0));
        @(posedge clk40);
        #1;
        chk("mid_rst_state2", 64'(state), 64'(0));
        chk("mid_rst_running", 64'(running), 64'(0));
        resetn = 1'b1;
        rec_ready = 1'b1;
        start_run = 1'b1;
        @(posedge clk40);
        #1;
        start_run = 1'b0;
        chk("post_rst_state", 64'(state), 64'(1));
        chk("post_rst_valid", 64'(rec_valid), 64'(0));
        @(posedge clk40);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
